lab_controller: RTL and testbench
=================================

Name: lab_controller

Overview:
- Sequencer for the LZ look-ahead buffer. Sits between the upstream 64-bit word stream, the look-ahead buffer and the match/encode core.
- Gates 8-byte pushes into the buffer using its ready/size outputs.
- Pre-fills the buffer to a minimum look-ahead depth, then converts core consume requests into remove_n_bytes pulses.
- Drains the buffer at end of stream and reports completion and byte counts.

Parameters:
- LENGTH, 100: look-ahead buffer depth in bytes; must match the buffer instance.
- N_BITS, 7: width of the byte index and remove count; buffer size is N_BITS+1 bits.
- MIN_LOOKAHEAD, 16: bytes required in the buffer before the window is presented to the core in RUN.
- CNT_W, 32: width of the byte counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a stream (honoured in IDLE only)
- in_valid  in  1  upstream word valid
- in_data  in  64  upstream word; byte 0 = [7:0]
- in_last  in  1  final word of the stream
- in_ready  out  1  upstream word accepted this cycle when in_valid && in_ready
- lab_data_in_valid  out  1  push strobe to the buffer
- lab_data_in  out  64  in_data passed through
- lab_remove_n_bytes  out  N_BITS  bytes to remove this cycle
- lab_get_byte_n  out  N_BITS  peek index to the buffer
- lab_size  in  N_BITS+1  buffer occupancy
- lab_buffer_ready  in  1  buffer has room for 8 bytes
- lab_byte_n  in  8  peeked byte
- lab_byte_n_valid  in  1  peek index is within occupancy
- peek_idx  in  N_BITS  core peek index
- peek_byte  out  8  lab_byte_n passed through
- peek_valid  out  1  lab_byte_n_valid && window_valid
- window_valid  out  1  core may peek and consume
- cons_valid  in  1  core consume request
- cons_n  in  N_BITS  bytes to consume
- cons_ready  out  1  consume accepted
- done  out  1  one-cycle pulse at end of drain
- underflow  out  1  sticky error flag
- bytes_in  out  CNT_W  bytes pushed this stream
- bytes_out  out  CNT_W  bytes removed this stream

Behaviour:
- States are IDLE, FILL, RUN, DRAIN, DONE.
- Reset puts the state in IDLE and forces all outputs low/zero. The buffer is reset on the same reset net, with polarity inverted at top level.
- Reset mid-stream abandons the stream immediately. No done pulse.
- IDLE:
  - in_ready=0, window_valid=0.
  - On start: go to FILL and clear bytes_in, bytes_out and underflow.
- Push (FILL and RUN only):
  - in_ready = lab_buffer_ready. Combinational; no registered output.
  - lab_data_in_valid = in_valid && in_ready. Zero latency; the buffer registers the word.
- FILL:
  - Go to RUN when lab_size >= MIN_LOOKAHEAD.
  - Go to DRAIN when the in_last word is accepted. This takes priority.
- RUN:
  - Go to DRAIN when the in_last word is accepted.
- window_valid = (RUN && lab_size >= MIN_LOOKAHEAD) || (DRAIN && lab_size != 0).
- Consume:
  - RUN: cons_ready = window_valid && cons_n != 0 && cons_n <= lab_size. A request with cons_n > lab_size stalls; no error is raised.
  - DRAIN: cons_ready = window_valid && cons_n != 0. The removed count is min(cons_n, lab_size). If cons_n > lab_size, underflow is set and stays set until the next start.
  - lab_remove_n_bytes = removed count when cons_valid && cons_ready, else 0.
- Push and consume in the same cycle are both allowed. The buffer handles the combined size (size + 8 - n); buffer_ready guarantees it cannot overflow.
- lab_get_byte_n = peek_idx, combinational.
- Counters:
  - bytes_in += 8 per push.
  - bytes_out += removed count per consume.
  - Both wrap modulo 2^CNT_W.
- DRAIN goes to DONE when lab_size == 0.
- DONE: done = 1 for one cycle, then IDLE.
- start outside IDLE is ignored.

Optional Feature:
- Macro: LAB_CTRL_STATS_EN.
- Defined:
  - Adds outputs push_stall_cycles[CNT_W-1:0], counting cycles with in_valid && !in_ready in FILL/RUN.
  - Adds outputs cons_stall_cycles[CNT_W-1:0], counting cycles with cons_valid && !cons_ready in RUN/DRAIN.
  - Both counters clear on reset and on start, and saturate at all-ones.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package lab_ctrl_pkg: state enum (IDLE, FILL, RUN, DRAIN, DONE) and the default constants for LENGTH, N_BITS and MIN_LOOKAHEAD.
- One sub-module, lab_ctrl_counter: clearable, enable-with-increment, wrap/saturate selectable. Instanced for bytes_in, bytes_out and, under the macro, the stall counters.

Test Plan:
- Start, 2 words pushed back-to-back → lab_size 16; RUN and window_valid=1 on the cycle after the second push; bytes_in=16.
- Push 12 words, no consumes → lab_size 96, lab_buffer_ready=0, in_ready=0; upstream word held. Then consume 8 → in_ready=1 on the next cycle.
- In RUN with lab_size 16: push plus cons_n=5 in the same cycle → lab_remove_n_bytes=5; lab_size 19 next cycle; bytes_out=5.
- In RUN with lab_size 16: cons_n=20 → cons_ready=0 every cycle; underflow stays 0; lab_remove_n_bytes=0.
- Single 8-byte word with in_last → DRAIN. Consume 3, 3, 3 → the third removes 2 and sets underflow=1. Then lab_size 0 → done pulse for one cycle → IDLE; bytes_out=8.
- Reset asserted in FILL after 1 push → next cycle IDLE, counters 0, in_ready=0, no done pulse. A new start works normally.

Source files
------------

// File: rtl/lab_ctrl_pkg.sv
// Shared types and default sizing for the look-ahead buffer sequencer.
package lab_ctrl_pkg;

  localparam int unsigned DefaultLength       = 100;
  localparam int unsigned DefaultNBits        = 7;
  localparam int unsigned DefaultMinLookahead = 16;
  localparam int unsigned DefaultCntW         = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StDrain,
    StDone
  } lab_state_e;

endpackage

// File: rtl/lab_ctrl_if.sv
// Upstream 64-bit word stream: master drives words, slave returns ready.
interface lab_ctrl_if;

  logic        in_valid;
  logic [63:0] in_data;
  logic        in_last;
  logic        in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/lab_ctrl_counter.sv
// Clearable counter with per-cycle increment; wraps or saturates at all-ones.
module lab_ctrl_counter #(
  parameter int unsigned Width    = 32,
  parameter bit          Saturate = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] incr,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;
  logic [Width:0]   sum;

  always_comb begin
    sum     = {1'b0, count_q} + {1'b0, incr};
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (Saturate && sum[Width]) ? '1 : sum[Width-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lab_controller.sv
// Look-ahead buffer sequencer: fill, run, drain and byte accounting.
// Optional stall counters are built when LAB_CTRL_STATS_EN is defined.
module lab_controller
  import lab_ctrl_pkg::*;
#(
  parameter int unsigned LENGTH        = DefaultLength,
  parameter int unsigned N_BITS        = DefaultNBits,
  parameter int unsigned MIN_LOOKAHEAD = DefaultMinLookahead,
  parameter int unsigned CNT_W         = DefaultCntW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  lab_ctrl_if.slave         up,
  output logic              lab_data_in_valid,
  output logic [63:0]       lab_data_in,
  output logic [N_BITS-1:0] lab_remove_n_bytes,
  output logic [N_BITS-1:0] lab_get_byte_n,
  input  logic [N_BITS:0]   lab_size,
  input  logic              lab_buffer_ready,
  input  logic [7:0]        lab_byte_n,
  input  logic              lab_byte_n_valid,
  input  logic [N_BITS-1:0] peek_idx,
  output logic [7:0]        peek_byte,
  output logic              peek_valid,
  output logic              window_valid,
  input  logic              cons_valid,
  input  logic [N_BITS-1:0] cons_n,
  output logic              cons_ready,
  output logic              done,
  output logic              underflow,
  output logic [CNT_W-1:0]  bytes_in,
  output logic [CNT_W-1:0]  bytes_out
`ifdef LAB_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]  push_stall_cycles,
  output logic [CNT_W-1:0]  cons_stall_cycles
`endif
);

  localparam int unsigned      SizeW     = N_BITS + 1;
  localparam logic [N_BITS:0]  MinSize   = SizeW'(MIN_LOOKAHEAD);
  localparam logic [N_BITS:0]  MaxSize   = SizeW'(LENGTH);
  localparam logic [CNT_W-1:0] WordBytes = CNT_W'(8);

  lab_state_e      state_q, state_d;
  logic            underflow_q, underflow_d;
  logic            in_fill_run, in_run, in_drain;
  logic            push, consume, over, start_take;
  logic [N_BITS:0] cons_ext;

  always_comb begin
    state_d            = state_q;
    underflow_d        = underflow_q;
    up.in_ready        = 1'b0;
    lab_data_in_valid  = 1'b0;
    window_valid       = 1'b0;
    cons_ready         = 1'b0;
    lab_remove_n_bytes = '0;
    done               = 1'b0;

    in_fill_run = !reset && (state_q == StFill || state_q == StRun);
    in_run      = !reset && (state_q == StRun);
    in_drain    = !reset && (state_q == StDrain);
    start_take  = !reset && (state_q == StIdle) && start;
    cons_ext    = {1'b0, cons_n};
    over        = cons_ext > lab_size;

    window_valid      = (in_run && lab_size >= MinSize) || (in_drain && lab_size != '0);
    up.in_ready       = in_fill_run && lab_buffer_ready;
    push              = up.in_valid && up.in_ready;
    lab_data_in_valid = push;

    // RUN stalls oversize requests; DRAIN accepts them and truncates to what is left.
    if (in_run) begin
      cons_ready = window_valid && (cons_n != '0) && !over;
    end else if (in_drain) begin
      cons_ready = window_valid && (cons_n != '0);
    end
    consume = cons_valid && cons_ready;
    if (consume) begin
      lab_remove_n_bytes = over ? lab_size[N_BITS-1:0] : cons_n;
    end

    done = !reset && (state_q == StDone);

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFill;
          underflow_d = 1'b0;
        end
      end
      StFill: begin
        if (push && up.in_last) begin
          state_d = StDrain;
        end else if (lab_size >= MinSize) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (push && up.in_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (consume && over) begin
          underflow_d = 1'b1;
        end
        if (lab_size == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      underflow_q <= underflow_d;
    end
  end

  assign underflow      = underflow_q;
  assign lab_data_in    = reset ? '0 : up.in_data;
  assign lab_get_byte_n = reset ? '0 : peek_idx;
  assign peek_byte      = reset ? '0 : lab_byte_n;
  assign peek_valid     = lab_byte_n_valid && window_valid;

  lab_ctrl_counter #(
    .Width    (CNT_W),
    .Saturate (1'b0)
  ) u_bytes_in (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_take),
    .enable (push),
    .incr   (WordBytes),
    .count  (bytes_in)
  );

  lab_ctrl_counter #(
    .Width    (CNT_W),
    .Saturate (1'b0)
  ) u_bytes_out (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_take),
    .enable (consume),
    .incr   (CNT_W'(lab_remove_n_bytes)),
    .count  (bytes_out)
  );

`ifdef LAB_CTRL_STATS_EN
  logic push_stall, cons_stall;

  assign push_stall = in_fill_run && up.in_valid && !up.in_ready;
  assign cons_stall = (in_run || in_drain) && cons_valid && !cons_ready;

  lab_ctrl_counter #(
    .Width    (CNT_W),
    .Saturate (1'b1)
  ) u_push_stall (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_take),
    .enable (push_stall),
    .incr   (CNT_W'(1)),
    .count  (push_stall_cycles)
  );

  lab_ctrl_counter #(
    .Width    (CNT_W),
    .Saturate (1'b1)
  ) u_cons_stall (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_take),
    .enable (cons_stall),
    .incr   (CNT_W'(1)),
    .count  (cons_stall_cycles)
  );
`endif

  // The buffer is sized to LENGTH; anything larger means a mismatched instance.
  a_size_bound : assert property (@(posedge clock) disable iff (reset) lab_size <= MaxSize);

endmodule

// File: tb/tb_lab_controller.sv
// Directed bench for lab_controller with a behavioural look-ahead buffer model.
module tb_lab_controller;

  localparam int Length = 100;

  logic        clock, reset, start;
  logic        lab_data_in_valid;
  logic [63:0] lab_data_in;
  logic [6:0]  lab_remove_n_bytes, lab_get_byte_n;
  logic [7:0]  lab_size;
  logic        lab_buffer_ready;
  logic [7:0]  lab_byte_n;
  logic        lab_byte_n_valid;
  logic [6:0]  peek_idx;
  logic [7:0]  peek_byte;
  logic        peek_valid, window_valid;
  logic        cons_valid;
  logic [6:0]  cons_n;
  logic        cons_ready, done, underflow;
  logic [31:0] bytes_in, bytes_out;
`ifdef LAB_CTRL_STATS_EN
  logic [31:0] push_stall_cycles, cons_stall_cycles;
`endif

  lab_ctrl_if up ();

  lab_controller dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .up                 (up),
    .lab_data_in_valid  (lab_data_in_valid),
    .lab_data_in        (lab_data_in),
    .lab_remove_n_bytes (lab_remove_n_bytes),
    .lab_get_byte_n     (lab_get_byte_n),
    .lab_size           (lab_size),
    .lab_buffer_ready   (lab_buffer_ready),
    .lab_byte_n         (lab_byte_n),
    .lab_byte_n_valid   (lab_byte_n_valid),
    .peek_idx           (peek_idx),
    .peek_byte          (peek_byte),
    .peek_valid         (peek_valid),
    .window_valid       (window_valid),
    .cons_valid         (cons_valid),
    .cons_n             (cons_n),
    .cons_ready         (cons_ready),
    .done               (done),
    .underflow          (underflow),
    .bytes_in           (bytes_in),
    .bytes_out          (bytes_out)
`ifdef LAB_CTRL_STATS_EN
    ,
    .push_stall_cycles  (push_stall_cycles),
    .cons_stall_cycles  (cons_stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Buffer model: remove from the front, then append the pushed word.
  logic [7:0] bmem [0:127];
  int bsize, rem, keep;

  always_comb begin
    rem  = int'(lab_remove_n_bytes);
    keep = (rem > bsize) ? 0 : bsize - rem;
  end

  always @(posedge clock) begin
    if (reset) begin
      bsize <= 0;
    end else begin
      for (int i = 0; i < 128; i++) begin
        if (i < keep) begin
          if (i + rem < 128) bmem[i] <= bmem[i + rem];
        end else if (lab_data_in_valid && i < keep + 8) begin
          bmem[i] <= lab_data_in[8*(i-keep) +: 8];
        end
      end
      bsize <= keep + (lab_data_in_valid ? 8 : 0);
    end
  end

  assign lab_size         = 8'(bsize);
  assign lab_buffer_ready = bsize <= Length - 8;
  assign lab_byte_n_valid = int'(lab_get_byte_n) < bsize;
  assign lab_byte_n       = lab_byte_n_valid ? bmem[lab_get_byte_n] : 8'h00;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic       iv;
    logic       cv;
    logic [6:0] n;
    logic       e_in_ready;
    logic       e_window;
    logic       e_cons_ready;
    logic [6:0] e_remove;
    logic [7:0] e_size;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pushes;
    int done_cnt;
    bit full;

    // Sequential RUN vectors starting from lab_size 16, bytes_out 0.
    vecs[0] = '{1'b1, 1'b1, 7'd5,  1'b1, 1'b1, 1'b1, 7'd5,  8'd19};
    vecs[1] = '{1'b0, 1'b1, 7'd20, 1'b1, 1'b1, 1'b0, 7'd0,  8'd19};
    vecs[2] = '{1'b0, 1'b1, 7'd0,  1'b1, 1'b1, 1'b0, 7'd0,  8'd19};
    vecs[3] = '{1'b0, 1'b1, 7'd3,  1'b1, 1'b1, 1'b1, 7'd3,  8'd16};
    vecs[4] = '{1'b0, 1'b1, 7'd20, 1'b1, 1'b1, 1'b0, 7'd0,  8'd16};
    vecs[5] = '{1'b0, 1'b1, 7'd16, 1'b1, 1'b1, 1'b1, 7'd16, 8'd0};
    vecs[6] = '{1'b0, 1'b1, 7'd1,  1'b1, 1'b0, 1'b0, 7'd0,  8'd0};
    vecs[7] = '{1'b1, 1'b0, 7'd0,  1'b1, 1'b0, 1'b0, 7'd0,  8'd8};
    vecs[8] = '{1'b1, 1'b1, 7'd1,  1'b1, 1'b0, 1'b0, 7'd0,  8'd16};
    vecs[9] = '{1'b0, 1'b1, 7'd4,  1'b1, 1'b1, 1'b1, 7'd4,  8'd12};

    reset       = 1'b1;
    start       = 1'b0;
    up.in_valid = 1'b1;
    up.in_data  = 64'h0000_0000_0000_0abc;
    up.in_last  = 1'b0;
    cons_valid  = 1'b0;
    cons_n      = '0;
    peek_idx    = '0;
    @(posedge clock);
    #1;
    chk("rst data_in", lab_data_in, 64'h0);
    chk("rst push", lab_data_in_valid, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("idle in_ready", up.in_ready, 1'b0);
    chk("idle push", lab_data_in_valid, 1'b0);
    chk("idle window", window_valid, 1'b0);
    chk("idle bytes_in", bytes_in, 0);
    chk("idle bytes_out", bytes_out, 0);
    chk("idle done", done, 1'b0);
    chk("idle underflow", underflow, 1'b0);
    up.in_valid = 1'b0;

    // Two back-to-back pushes reach the minimum look-ahead.
    do_start();
    up.in_valid = 1'b1;
    up.in_data  = 64'h1716_1514_1312_1110;
    #1;
    chk("fill push", lab_data_in_valid, 1'b1);
    tick();
    tick();
    up.in_valid = 1'b0;
    chk("fill size16", lab_size, 16);
    chk("fill bytes_in", bytes_in, 16);
    tick();
    chk("run window", window_valid, 1'b1);

    for (int i = 0; i < 10; i++) begin
      up.in_valid = vecs[i].iv;
      cons_valid  = vecs[i].cv;
      cons_n      = vecs[i].n;
      #1;
      chk($sformatf("vec%0d in_ready", i), up.in_ready, vecs[i].e_in_ready);
      chk($sformatf("vec%0d window", i), window_valid, vecs[i].e_window);
      chk($sformatf("vec%0d cons_ready", i), cons_ready, vecs[i].e_cons_ready);
      chk($sformatf("vec%0d remove", i), lab_remove_n_bytes, vecs[i].e_remove);
      tick();
      up.in_valid = 1'b0;
      cons_valid  = 1'b0;
      chk($sformatf("vec%0d size", i), lab_size, vecs[i].e_size);
    end
    chk("run bytes_out", bytes_out, 28);
    chk("run bytes_in", bytes_in, 40);
    chk("run underflow", underflow, 1'b0);

    // Fill until the buffer refuses, then free one word of room.
    do_reset();
    do_start();
    up.in_valid = 1'b1;
    pushes = 0;
    full   = 1'b0;
    for (int c = 0; c < 40 && !full; c++) begin
      #1;
      if (!up.in_ready) begin
        full = 1'b1;
      end else begin
        if (lab_data_in_valid) pushes++;
        @(posedge clock);
      end
    end
    chk("full reached", full, 1'b1);
    chk("full pushes", pushes, 12);
    chk("full size", lab_size, 96);
    chk("full held", lab_data_in_valid, 1'b0);
    cons_valid = 1'b1;
    cons_n     = 7'd8;
    #1;
    chk("full remove", lab_remove_n_bytes, 8);
    tick();
    cons_valid = 1'b0;
    chk("room size", lab_size, 88);
    chk("room in_ready", up.in_ready, 1'b1);
    chk("room push", lab_data_in_valid, 1'b1);
    tick();
    up.in_valid = 1'b0;
    chk("room bytes_in", bytes_in, 104);

    // Single last word, drained with an oversize final consume.
    do_reset();
    do_start();
    up.in_valid = 1'b1;
    up.in_last  = 1'b1;
    up.in_data  = 64'h0706_0504_0302_0100;
    #1;
    chk("last push", lab_data_in_valid, 1'b1);
    tick();
    up.in_last = 1'b0;
    #1;
    chk("drain in_ready", up.in_ready, 1'b0);
    chk("drain no push", lab_data_in_valid, 1'b0);
    up.in_valid = 1'b0;
    chk("drain window", window_valid, 1'b1);
    peek_idx = 7'd2;
    #1;
    chk("peek idx", lab_get_byte_n, 2);
    chk("peek byte", peek_byte, 8'h02);
    chk("peek valid", peek_valid, 1'b1);
    peek_idx = 7'd9;
    #1;
    chk("peek oob", peek_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cons_valid = 1'b1;
      cons_n     = 7'd3;
      #1;
      chk($sformatf("drain%0d cons_ready", k), cons_ready, 1'b1);
      chk($sformatf("drain%0d remove", k), lab_remove_n_bytes, (k == 2) ? 2 : 3);
      tick();
      cons_valid = 1'b0;
      if (k == 0) begin
        peek_idx = 7'd0;
        #1;
        chk("peek shifted", peek_byte, 8'h03);
      end
    end
    chk("drain underflow", underflow, 1'b1);
    chk("drain empty window", window_valid, 1'b0);
    chk("drain no done", done, 1'b0);
    tick();
    chk("done pulse", done, 1'b1);
    tick();
    chk("done cleared", done, 1'b0);
    chk("post idle in_ready", up.in_ready, 1'b0);
    chk("drain bytes_out", bytes_out, 8);
    chk("underflow sticky", underflow, 1'b1);
    do_start();
    chk("start clears underflow", underflow, 1'b0);
    chk("start clears bytes_out", bytes_out, 0);

    // Reset during FILL abandons the stream.
    up.in_valid = 1'b1;
    tick();
    up.in_valid = 1'b0;
    chk("abort bytes_in pre", bytes_in, 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort in_ready", up.in_ready, 1'b0);
    chk("abort bytes_in", bytes_in, 0);
    chk("abort size", lab_size, 0);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("abort no done", done_cnt, 0);
    do_start();
    up.in_valid = 1'b1;
    tick();
    tick();
    up.in_valid = 1'b0;
    tick();
    chk("restart bytes_in", bytes_in, 16);
    chk("restart window", window_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
